// File: rtl/systolic_fir_array.sv
// Weight-stationary systolic FIR engine with LOAD/RUN modes, a three-stage pipeline
// (history shift, per-tap products, adder tree) and a credit-protected output FIFO.
module systolic_fir_array #(
   parameter int width_p     = 8,
   parameter int taps_p      = 8,
   parameter int acc_width_p = 2*width_p + $clog2(taps_p),
   parameter int fifo_els_p  = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   en_i,
   input  logic                   mode_i,
   input  logic                   flush_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [width_p-1:0]     data_i,
   output logic                   valid_o,
   input  logic                   yumi_i,
   output logic [acc_width_p-1:0] data_o,
   output logic                   busy_o,
   output logic                   idle_o,
   output logic [3:0]             onehot_o
);
   localparam int prod_w_lp = 2*width_p;
   localparam int tap_w_lp  = $clog2(taps_p);
   localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
   localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
   localparam int crd_w_lp  = cnt_w_lp + 1;

   typedef enum logic [1:0] {st_idle, st_load, st_run, st_drain} state_e;

   state_e                 state_q, state_d;
   logic [tap_w_lp-1:0]    tap_cnt_q, tap_cnt_d;
   logic                   alive_q, alive_d;
   logic                   busy_q, busy_d;
   logic [3:0]             onehot_q, onehot_d;
   logic [width_p-1:0]     coef_q [taps_p];
   logic [width_p-1:0]     coef_d [taps_p];
   logic [width_p-1:0]     hist_q [taps_p];
   logic [width_p-1:0]     hist_d [taps_p];
   logic [prod_w_lp-1:0]   prod_q [taps_p];
   logic [prod_w_lp-1:0]   prod_d [taps_p];
   logic                   hist_v_q, hist_v_d, prod_v_q, prod_v_d, sum_v_q, sum_v_d;
   logic [acc_width_p-1:0] sum_q, sum_d;
   logic [acc_width_p-1:0] mem_q [fifo_els_p];
   logic [acc_width_p-1:0] mem_d [fifo_els_p];
   logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0]    count_q, count_d;

   logic [crd_w_lp-1:0]    credit;
   logic                   accept, push, pop, pipe_empty, take_sample, clear_hist;

   assign pipe_empty = ~(hist_v_q | prod_v_q | sum_v_q);
   // Every accepted beat holds a credit until it is popped, so the FIFO can never overflow.
   assign credit     = crd_w_lp'(count_q) + crd_w_lp'(hist_v_q) + crd_w_lp'(prod_v_q)
                     + crd_w_lp'(sum_v_q);
   assign ready_o    = en_i & alive_q & (state_q != st_drain) & (credit < crd_w_lp'(fifo_els_p));
   assign accept     = valid_i & ready_o & ~flush_i;
   assign valid_o    = (count_q != '0);
   assign pop        = yumi_i & valid_o;
   assign push       = en_i & sum_v_q;
   assign data_o     = mem_q[rd_ptr_q];
   assign busy_o     = busy_q;
   assign onehot_o   = onehot_q;
   assign idle_o     = (state_q == st_idle) & pipe_empty & ~valid_o;

   always_comb begin
      // NOTE: every _d starts from its _q, so no branch below can leave a latch behind.
      state_d     = state_q;
      tap_cnt_d   = tap_cnt_q;
      alive_d     = 1'b1;
      coef_d      = coef_q;
      hist_d      = hist_q;
      prod_d      = prod_q;
      hist_v_d    = hist_v_q;
      prod_v_d    = prod_v_q;
      sum_v_d     = sum_v_q;
      sum_d       = sum_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      take_sample = 1'b0;
      clear_hist  = 1'b0;

      if (en_i) begin
         hist_v_d = 1'b0;
         prod_v_d = hist_v_q;
         sum_v_d  = prod_v_q;
         sum_d    = '0;
         for (int k = 0; k < taps_p; k++) begin
            prod_d[k] = prod_w_lp'(coef_q[k]) * prod_w_lp'(hist_q[k]);
            sum_d     = sum_d + acc_width_p'(prod_q[k]);
         end
         unique case (state_q)
            st_idle:
               if (flush_i) clear_hist = 1'b1;
               else if (accept && mode_i) begin
                  coef_d[0] = data_i;
                  tap_cnt_d = tap_w_lp'(1);
                  state_d   = st_load;
               end else if (accept) begin
                  take_sample = 1'b1;
                  state_d     = st_run;
               end
            st_load:
               if (flush_i) begin
                  tap_cnt_d = '0;
                  state_d   = st_idle;
               end else if (accept) begin
                  coef_d[tap_cnt_q] = data_i;
                  if (tap_cnt_q == tap_w_lp'(taps_p - 1)) begin
                     tap_cnt_d = '0;
                     state_d   = st_idle;
                  end else tap_cnt_d = tap_cnt_q + tap_w_lp'(1);
               end
            st_run:
               if (flush_i) state_d = st_drain;
               else if (accept) take_sample = 1'b1;
            st_drain:
               if (pipe_empty && !valid_o) begin
                  clear_hist = 1'b1;
                  state_d    = st_idle;
               end
         endcase
         if (take_sample) begin
            hist_v_d  = 1'b1;
            hist_d[0] = data_i;
            for (int k = 1; k < taps_p; k++) hist_d[k] = hist_q[k-1];
         end
         if (clear_hist) begin
            for (int k = 0; k < taps_p; k++) hist_d[k] = '0;
         end
      end

      busy_d = (state_d != st_idle);
      unique case (state_d)
         st_idle:  onehot_d = 4'b0001;
         st_load:  onehot_d = 4'b0010;
         st_run:   onehot_d = 4'b0100;
         st_drain: onehot_d = 4'b1000;
      endcase

      // The output side keeps popping while en_i is low; only the push is frozen.
      if (push) begin
         mem_d[wr_ptr_q] = sum_q;
         wr_ptr_d = (wr_ptr_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_q + ptr_w_lp'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_q + ptr_w_lp'(1);
      count_d = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
   end

   // NOTE: coefficient, history and FIFO storage are reset as well, because a reset must
   // discard loaded taps and leave data_o at zero.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= st_idle;
         tap_cnt_q <= '0;
         alive_q   <= 1'b0;
         busy_q    <= 1'b0;
         onehot_q  <= 4'b0001;
         hist_v_q  <= 1'b0;
         prod_v_q  <= 1'b0;
         sum_v_q   <= 1'b0;
         sum_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int k = 0; k < taps_p; k++) begin
            coef_q[k] <= '0;
            hist_q[k] <= '0;
            prod_q[k] <= '0;
         end
         for (int i = 0; i < fifo_els_p; i++) mem_q[i] <= '0;
      end else begin
         // NOTE: non-blocking updates make every flop see pre-edge values regardless of order.
         state_q   <= state_d;
         tap_cnt_q <= tap_cnt_d;
         alive_q   <= alive_d;
         busy_q    <= busy_d;
         onehot_q  <= onehot_d;
         hist_v_q  <= hist_v_d;
         prod_v_q  <= prod_v_d;
         sum_v_q   <= sum_v_d;
         sum_q     <= sum_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         coef_q    <= coef_d;
         hist_q    <= hist_d;
         prod_q    <= prod_d;
         mem_q     <= mem_d;
      end
   end
endmodule

// File: tb/tb_systolic_fir_array.sv
// Directed bench for systolic_fir_array: reset, impulse, streaming, backpressure,
// full-scale math, flush priority and enable freeze, all against hand-computed results.
module tb_systolic_fir_array;
   logic        clk_i   = 1'b0;
   logic        reset_i = 1'b0;
   logic        en_i    = 1'b1;
   logic        mode_i  = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        yumi_i  = 1'b0;
   logic [7:0]  data_i  = '0;
   logic        ready_o, valid_o, busy_o, idle_o;
   logic [18:0] data_o;
   logic [3:0]  onehot_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_accept_cyc = 0;
   logic [18:0] got[$];

   systolic_fir_array #(
      .width_p(8), .taps_p(8), .acc_width_p(19), .fifo_els_p(4)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .mode_i(mode_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .valid_o(valid_o),
      .yumi_i(yumi_i), .data_o(data_o), .busy_o(busy_o), .idle_o(idle_o), .onehot_o(onehot_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   // Record every result the consumer takes; inputs are stable at the falling edge.
   always @(negedge clk_i) if (reset_i && valid_o && yumi_i) got.push_back(data_o);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic m);
      int n = 0;
      logic ok = 1'b0;
      valid_i = 1'b1;
      data_i  = d;
      mode_i  = m;
      while (!ok && n < 100) begin
         @(negedge clk_i);
         ok = ready_o & ~flush_i;
         tick();
         n++;
      end
      valid_i = 1'b0;
      if (ok) last_accept_cyc = cyc;
      else check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic load_coefs(input logic [7:0] c [8]);
      send(c[0], 1'b1);
      check("load_state", onehot_o, 4'b0010);
      for (int k = 1; k < 8; k++) send(c[k], 1'b1);
      check("load_done", onehot_o, 4'b0001);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!idle_o && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, idle_o, 1'b1);
   endtask

   task automatic end_run(input string tag);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      wait_idle(tag);
   endtask

   function automatic int fir_ones(input int n);
      int s = 0;
      for (int k = 0; k < 8; k++) if (n - k >= 0) s += n - k;
      return s;
   endfunction

   initial begin
      int base;
      int acc;
      int a0;
      logic [18:0] exp4 [4];

      // T1 reset
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready", ready_o, 1'b0);
      check("rst_valid", valid_o, 1'b0);
      check("rst_data", data_o, 19'd0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_idle", idle_o, 1'b1);
      check("rst_onehot", onehot_o, 4'b0001);
      reset_i = 1'b1;
      tick();
      check("post_rst_ready", ready_o, 1'b1);
      check("post_rst_idle", idle_o, 1'b1);
      check("post_rst_onehot", onehot_o, 4'b0001);

      // T2 impulse
      load_coefs('{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      yumi_i = 1'b1;
      base = got.size();
      send(8'd1, 1'b0);
      check("run_state", onehot_o, 4'b0100);
      check("run_busy", busy_o, 1'b1);
      repeat (3) send(8'd0, 1'b0);
      end_run("t2");
      exp4 = '{19'd1, 19'd2, 19'd3, 19'd0};
      check("t2_count", got.size() - base, 4);
      for (int i = 0; i < 4; i++) check($sformatf("t2_y%0d", i), got[base+i], exp4[i]);

      // T3 throughput with all-ones taps
      load_coefs('{default: 8'd1});
      base = got.size();
      send(8'd0, 1'b0);
      a0 = last_accept_cyc;
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      check("t3_lat_early", valid_o, 1'b0);
      send(8'd3, 1'b0);
      check("t3_lat", valid_o, 1'b1);
      check("t3_accept_gap", last_accept_cyc - a0, 3);
      for (int n = 4; n < 100; n++) send(8'(n), 1'b0);
      end_run("t3");
      check("t3_count", got.size() - base, 100);
      acc = 0;
      for (int n = 0; n < 100; n++) if (got[base+n] !== 19'(fir_ones(n))) acc++;
      check("t3_bad_results", acc, 0);
      check("t3_y7", got[base+7], 19'd28);
      check("t3_y99", got[base+99], 19'd764);

      // T4 backpressure: history was cleared by the drain, taps still all ones
      yumi_i  = 1'b0;
      base    = got.size();
      acc     = 0;
      valid_i = 1'b1;
      mode_i  = 1'b0;
      data_i  = 8'd10;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (ready_o) acc++;
         tick();
         data_i = 8'(10 * (acc + 1));
      end
      valid_i = 1'b0;
      check("t4_accepts", acc, 4);
      check("t4_ready", ready_o, 1'b0);
      check("t4_valid", valid_o, 1'b1);
      yumi_i = 1'b1;
      end_run("t4");
      exp4 = '{19'd10, 19'd30, 19'd60, 19'd100};
      check("t4_count", got.size() - base, 4);
      for (int i = 0; i < 4; i++) check($sformatf("t4_y%0d", i), got[base+i], exp4[i]);

      // T5 full-scale math
      load_coefs('{default: 8'd255});
      base = got.size();
      repeat (8) send(8'd255, 1'b0);
      end_run("t5");
      check("t5_count", got.size() - base, 8);
      check("t5_y0", got[base], 19'd65025);
      check("t5_y7", got[base+7], 19'd520200);

      // T6 flush with two results queued; flush beats a valid beat on the same edge
      load_coefs('{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      yumi_i = 1'b0;
      base   = got.size();
      send(8'd7, 1'b0);
      send(8'd9, 1'b0);
      repeat (5) tick();
      check("t6_queued", valid_o, 1'b1);
      valid_i = 1'b1;
      data_i  = 8'd99;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      check("t6_drain_state", onehot_o, 4'b1000);
      check("t6_drain_ready", ready_o, 1'b0);
      yumi_i = 1'b1;
      wait_idle("t6a");
      check("t6_count", got.size() - base, 2);
      check("t6_y0", got[base], 19'd7);
      check("t6_y1", got[base+1], 19'd9);
      base = got.size();
      send(8'd5, 1'b0);
      end_run("t6b");
      check("t6_after_flush", got[base], 19'd5);

      // T6 enable freeze mid-run
      base = got.size();
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      send(8'd3, 1'b0);
      en_i    = 1'b0;
      valid_i = 1'b1;
      data_i  = 8'd4;
      acc     = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         if (ready_o) acc++;
         tick();
      end
      check("t6_frozen_accepts", acc, 0);
      check("t6_frozen_results", got.size() - base, 0);
      check("t6_frozen_state", onehot_o, 4'b0100);
      en_i = 1'b1;
      send(8'd4, 1'b0);
      end_run("t6c");
      exp4 = '{19'd1, 19'd2, 19'd3, 19'd4};
      check("t6_resume_count", got.size() - base, 4);
      for (int i = 0; i < 4; i++) check($sformatf("t6_resume_y%0d", i), got[base+i], exp4[i]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
